// File: rtl/data_router_pkg.sv
// Shared types for the data_router / data_merger pair: config word layout,
// length width and the merger phase FSM encoding.
package data_router_pkg;

  localparam int unsigned FIELD_W = 5;
  localparam int unsigned LEN_W   = 10;

  // Packed config word, MSB first.
  typedef struct packed {
    logic [FIELD_W-1:0] symbol_1;
    logic [FIELD_W-1:0] prb_1;
    logic [FIELD_W-1:0] symbol_2;
    logic [FIELD_W-1:0] prb_2;
    logic [FIELD_W-1:0] symbol_3;
    logic [FIELD_W-1:0] prb_3;
  } config_param_1;

  typedef enum logic [1:0] {StIdle, StPh1, StPh2, StPh3} merger_state_t;

  // First phase after cur whose length is non-zero; StIdle when none remain.
  function automatic merger_state_t next_phase(merger_state_t cur,
                                               logic [LEN_W-1:0] len_1,
                                               logic [LEN_W-1:0] len_2,
                                               logic [LEN_W-1:0] len_3);
    if (cur == StIdle && len_1 != '0) return StPh1;
    if ((cur == StIdle || cur == StPh1) && len_2 != '0) return StPh2;
    if (cur != StPh3 && len_3 != '0) return StPh3;
    return StIdle;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-stage AXI-Stream output register with valid/ready hold.
// Optional m_axi_last pipelining is enabled by DATA_MERGER_LAST_EN.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
`ifdef DATA_MERGER_LAST_EN
  input  logic                  load_last,
  output logic                  out_last,
`endif
  input  logic                  out_ready,
  output logic                  can_load,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // A new beat may enter when the register is empty or draining this cycle.
  always_comb can_load = !out_valid || out_ready;

  // Register the accepted beat; drop valid once the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef DATA_MERGER_LAST_EN
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
`ifdef DATA_MERGER_LAST_EN
      out_last  <= load_last;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_merger.sv
// Gathers three per-stream AXI-Stream inputs into one serial stream, taking
// symbol_k*prb_k beats from each stream k in order per accepted config word.
// Define DATA_MERGER_LAST_EN to add m_axi_last on the final beat of a frame.
module data_merger
  import data_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned CONFIG_BIT_WIDTH = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CONFIG_BIT_WIDTH-1:0] s_axi_config_data,
  input  logic                        s_axi_config_valid,
  output logic                        s_axi_config_ready,
  input  logic [DATA_WIDTH-1:0]       in_axi_data_1,
  input  logic                        in_axi_valid_1,
  output logic                        in_axi_ready_1,
  input  logic [DATA_WIDTH-1:0]       in_axi_data_2,
  input  logic                        in_axi_valid_2,
  output logic                        in_axi_ready_2,
  input  logic [DATA_WIDTH-1:0]       in_axi_data_3,
  input  logic                        in_axi_valid_3,
  output logic                        in_axi_ready_3,
`ifdef DATA_MERGER_LAST_EN
  output logic                        m_axi_last,
`endif
  output logic [DATA_WIDTH-1:0]       m_axi_data,
  output logic                        m_axi_valid,
  input  logic                        m_axi_ready
);

  merger_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_1_q, len_2_q, len_3_q;
  logic [LEN_W-1:0] len_1_d, len_2_d, len_3_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  config_param_1    cfg;
  logic [LEN_W-1:0] cfg_len_1, cfg_len_2, cfg_len_3;
  logic             cfg_fire;
  logic             can_load;
  logic             sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [LEN_W-1:0] cur_len;
  logic             in_fire;
  logic             last_beat;

  assign cfg       = config_param_1'(s_axi_config_data);
  // 5x5-bit products fit in 10 bits (max 961).
  assign cfg_len_1 = LEN_W'(cfg.symbol_1) * LEN_W'(cfg.prb_1);
  assign cfg_len_2 = LEN_W'(cfg.symbol_2) * LEN_W'(cfg.prb_2);
  assign cfg_len_3 = LEN_W'(cfg.symbol_3) * LEN_W'(cfg.prb_3);

  assign s_axi_config_ready = (state_q == StIdle);
  assign cfg_fire           = s_axi_config_valid && s_axi_config_ready;

  // Readies depend only on state and the output register, never on valid.
  assign in_axi_ready_1 = (state_q == StPh1) && can_load;
  assign in_axi_ready_2 = (state_q == StPh2) && can_load;
  assign in_axi_ready_3 = (state_q == StPh3) && can_load;

  // Select the stream, and its length, belonging to the active phase.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    cur_len   = '0;
    unique case (state_q)
      StPh1: begin sel_valid = in_axi_valid_1; sel_data = in_axi_data_1; cur_len = len_1_q; end
      StPh2: begin sel_valid = in_axi_valid_2; sel_data = in_axi_data_2; cur_len = len_2_q; end
      StPh3: begin sel_valid = in_axi_valid_3; sel_data = in_axi_data_3; cur_len = len_3_q; end
      default: ;
    endcase
  end

  assign in_fire   = sel_valid && can_load && (state_q != StIdle);
  assign last_beat = in_fire && (beat_cnt_q == cur_len - LEN_W'(1));

  // Next-state: latch lengths in IDLE, count beats and advance phases.
  always_comb begin
    state_d    = state_q;
    len_1_d    = len_1_q;
    len_2_d    = len_2_q;
    len_3_d    = len_3_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == StIdle) begin
      if (cfg_fire) begin
        len_1_d = cfg_len_1;
        len_2_d = cfg_len_2;
        len_3_d = cfg_len_3;
        state_d = next_phase(StIdle, cfg_len_1, cfg_len_2, cfg_len_3);
      end
    end else if (in_fire) begin
      if (last_beat) begin
        beat_cnt_d = '0;
        state_d    = next_phase(state_q, len_1_q, len_2_q, len_3_q);
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end
  end

  // FSM and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_1_q    <= '0;
      len_2_q    <= '0;
      len_3_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_1_q    <= len_1_d;
      len_2_q    <= len_2_d;
      len_3_q    <= len_3_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DATA_MERGER_LAST_EN
  logic frame_last;
  // Last beat of the last non-empty phase ends the frame.
  assign frame_last = last_beat && (state_d == StIdle);
`endif

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (in_fire),
    .load_data (sel_data),
`ifdef DATA_MERGER_LAST_EN
    .load_last (frame_last),
    .out_last  (m_axi_last),
`endif
    .out_ready (m_axi_ready),
    .can_load  (can_load),
    .out_valid (m_axi_valid),
    .out_data  (m_axi_data)
  );

endmodule

// File: tb/tb_data_merger.sv
// Directed self-checking bench for data_merger. Stream k presents beat i as
// {k, i} with valid held high; output beats are collected and compared.
// Define DATA_MERGER_LAST_EN to also check m_axi_last.
module tb_data_merger;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] s_axi_config_data;
  logic        s_axi_config_valid;
  logic        s_axi_config_ready;
  logic [63:0] in_axi_data_1, in_axi_data_2, in_axi_data_3;
  logic        in_axi_valid_1, in_axi_valid_2, in_axi_valid_3;
  logic        in_axi_ready_1, in_axi_ready_2, in_axi_ready_3;
  logic [63:0] m_axi_data;
  logic        m_axi_valid;
  logic        m_axi_ready;
`ifdef DATA_MERGER_LAST_EN
  logic        m_axi_last;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned idx_1, idx_2, idx_3;
  logic [63:0] got[$];
  logic        got_last[$];
  logic        saw_ready_2;
  logic        stall_pending;
  logic [63:0] held_data;
  int unsigned stable_err;

  always #5 clk = ~clk;

  data_merger #(
    .DATA_WIDTH       (64),
    .CONFIG_BIT_WIDTH (30)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .s_axi_config_data  (s_axi_config_data),
    .s_axi_config_valid (s_axi_config_valid),
    .s_axi_config_ready (s_axi_config_ready),
    .in_axi_data_1      (in_axi_data_1),
    .in_axi_valid_1     (in_axi_valid_1),
    .in_axi_ready_1     (in_axi_ready_1),
    .in_axi_data_2      (in_axi_data_2),
    .in_axi_valid_2     (in_axi_valid_2),
    .in_axi_ready_2     (in_axi_ready_2),
    .in_axi_data_3      (in_axi_data_3),
    .in_axi_valid_3     (in_axi_valid_3),
    .in_axi_ready_3     (in_axi_ready_3),
`ifdef DATA_MERGER_LAST_EN
    .m_axi_last         (m_axi_last),
`endif
    .m_axi_data         (m_axi_data),
    .m_axi_valid        (m_axi_valid),
    .m_axi_ready        (m_axi_ready)
  );

  function automatic logic [63:0] bt(int unsigned k, int unsigned i);
    return {k, i};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    in_axi_data_1 = bt(1, idx_1);
    in_axi_data_2 = bt(2, idx_2);
    in_axi_data_3 = bt(3, idx_3);
  endtask

  task automatic restart_streams();
    idx_1 = 0; idx_2 = 0; idx_3 = 0;
    got.delete();
    got_last.delete();
    stall_pending = 1'b0;
    drive_data();
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic tick(output logic cfg_done);
    logic f1, f2, f3, fo, ol;
    logic [63:0] od;
    #1;
    f1 = in_axi_valid_1 && in_axi_ready_1;
    f2 = in_axi_valid_2 && in_axi_ready_2;
    f3 = in_axi_valid_3 && in_axi_ready_3;
    fo = m_axi_valid && m_axi_ready;
    od = m_axi_data;
`ifdef DATA_MERGER_LAST_EN
    ol = m_axi_last;
`else
    ol = 1'b0;
`endif
    cfg_done = s_axi_config_valid && s_axi_config_ready;
    if (in_axi_ready_2) saw_ready_2 = 1'b1;
    if (stall_pending && m_axi_data !== held_data) stable_err++;
    stall_pending = m_axi_valid && !m_axi_ready;
    held_data     = m_axi_data;
    @(posedge clk);
    #1;
    if (f1) idx_1++;
    if (f2) idx_2++;
    if (f3) idx_3++;
    if (fo) begin
      got.push_back(od);
      got_last.push_back(ol);
    end
    drive_data();
  endtask

  task automatic run(int unsigned n);
    logic d;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  task automatic send_cfg(string tag, logic [4:0] s1, logic [4:0] p1, logic [4:0] s2,
                          logic [4:0] p2, logic [4:0] s3, logic [4:0] p3);
    logic done;
    done = 1'b0;
    s_axi_config_data  = {s1, p1, s2, p2, s3, p3};
    s_axi_config_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) tick(done);
    s_axi_config_valid = 1'b0;
    chk({tag, "_cfg_accept"}, 64'(done), 64'd1);
  endtask

  task automatic check_seq(string tag, logic [63:0] exp[$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    logic [63:0] exp[$];
    logic        d;
    reset              = 1'b1;
    m_axi_ready        = 1'b1;
    s_axi_config_data  = '0;
    s_axi_config_valid = 1'b0;
    in_axi_valid_1     = 1'b1;
    in_axi_valid_2     = 1'b1;
    in_axi_valid_3     = 1'b1;
    saw_ready_2        = 1'b0;
    stable_err         = 0;
    held_data          = '0;
    restart_streams();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_axi_valid), 64'd0);
    chk("rst_m_data", m_axi_data, 64'd0);
    chk("rst_ready_1", 64'(in_axi_ready_1), 64'd0);
    chk("rst_ready_2", 64'(in_axi_ready_2), 64'd0);
    chk("rst_ready_3", 64'(in_axi_ready_3), 64'd0);
    chk("rst_cfg_ready", 64'(s_axi_config_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Basic 6-beat frame with first-beat latency check.
    restart_streams();
    send_cfg("t1", 5'd1, 5'd2, 5'd1, 5'd3, 5'd1, 5'd1);
    chk("t1_ready_1", 64'(in_axi_ready_1), 64'd1);
    chk("t1_valid_before", 64'(m_axi_valid), 64'd0);
    chk("t1_cfg_ready_busy", 64'(s_axi_config_ready), 64'd0);
    tick(d);
    chk("t1_first_valid", 64'(m_axi_valid), 64'd1);
    chk("t1_first_data", m_axi_data, bt(1, 0));
    run(15);
    exp = '{bt(1, 0), bt(1, 1), bt(2, 0), bt(2, 1), bt(2, 2), bt(3, 0)};
    check_seq("t1", exp);
`ifdef DATA_MERGER_LAST_EN
    for (int i = 0; i < got_last.size(); i++)
      chk($sformatf("t1_last%0d", i), 64'(got_last[i]), 64'(i == 5));
`endif

    // Phase 2 empty: skipped, its ready never raised.
    restart_streams();
    saw_ready_2 = 1'b0;
    send_cfg("t2", 5'd2, 5'd2, 5'd0, 5'd5, 5'd1, 5'd3);
    run(15);
    exp = '{bt(1, 0), bt(1, 1), bt(1, 2), bt(1, 3), bt(3, 0), bt(3, 1), bt(3, 2)};
    check_seq("t2", exp);
    chk("t2_no_ready_2", 64'(saw_ready_2), 64'd0);

    // All-zero config is consumed and produces nothing.
    restart_streams();
    send_cfg("t3a", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("t3_stays_idle", 64'(s_axi_config_ready), 64'd1);
    run(8);
    chk("t3_zero_beats", 64'(got.size()), 64'd0);
    send_cfg("t3b", 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1);
    run(10);
    exp = '{bt(1, 0), bt(2, 0), bt(3, 0)};
    check_seq("t3", exp);

    // Backpressure 1-on/2-off: same order, data stable while stalled.
    restart_streams();
    stable_err = 0;
    send_cfg("t4", 5'd1, 5'd2, 5'd1, 5'd3, 5'd1, 5'd1);
    for (int c = 0; c < 40; c++) begin
      m_axi_ready = (c % 3 == 0);
      tick(d);
    end
    m_axi_ready = 1'b1;
    run(4);
    exp = '{bt(1, 0), bt(1, 1), bt(2, 0), bt(2, 1), bt(2, 2), bt(3, 0)};
    check_seq("t4", exp);
    chk("t4_stable", 64'(stable_err), 64'd0);

    // Reset mid-frame after three delivered beats.
    restart_streams();
    send_cfg("t5", 5'd1, 5'd2, 5'd1, 5'd3, 5'd1, 5'd1);
    for (int i = 0; i < 50 && got.size() < 3; i++) tick(d);
    chk("t5_three_out", 64'(got.size()), 64'd3);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(m_axi_valid), 64'd0);
    chk("t5_rst_data", m_axi_data, 64'd0);
    chk("t5_rst_readies", 64'({in_axi_ready_1, in_axi_ready_2, in_axi_ready_3}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    restart_streams();
    send_cfg("t5b", 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1);
    run(10);
    exp = '{bt(1, 0), bt(2, 0), bt(3, 0)};
    check_seq("t5", exp);

`ifdef DATA_MERGER_LAST_EN
    // Last on the stream-2 beat when phase 3 is empty.
    restart_streams();
    send_cfg("t6", 5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0);
    run(8);
    exp = '{bt(1, 0), bt(2, 0)};
    check_seq("t6", exp);
    for (int i = 0; i < got_last.size(); i++)
      chk($sformatf("t6_last%0d", i), 64'(got_last[i]), 64'(i == 1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_merger.md
Name: data_merger

Overview:
- Inverse of data_router: gathers three per-stream AXI-Stream inputs back into one serial output stream.
- Per accepted config word, emits symbol_1*prb_1 beats from stream 1, then symbol_2*prb_2 beats from stream 2, then symbol_3*prb_3 beats from stream 3.
- Sits at the receive-side reassembly point, consuming the same config format the router consumes.

Parameters:
- DATA_WIDTH, 64, width of every data bus.
- CONFIG_BIT_WIDTH, 30, config word width; equals the packed size of config_param_1 (six 5-bit fields).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axi_config_data  in  CONFIG_BIT_WIDTH  packed config, MSB first: symbol_1[29:25] prb_1[24:20] symbol_2[19:15] prb_2[14:10] symbol_3[9:5] prb_3[4:0].
- s_axi_config_valid  in  1  config valid.
- s_axi_config_ready  out  1  config ready.
- in_axi_data_k  in  DATA_WIDTH  stream k data, k=1..3.
- in_axi_valid_k  in  1  stream k valid.
- in_axi_ready_k  out  1  stream k ready.
- m_axi_data  out  DATA_WIDTH  merged output data.
- m_axi_valid  out  1  merged output valid.
- m_axi_ready  in  1  merged output ready.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all counters 0.
  - m_axi_valid=0, m_axi_data=0.
  - in_axi_ready_k=0; s_axi_config_ready=1.
- FSM states: IDLE, PH1, PH2, PH3.
- IDLE:
  - s_axi_config_ready=1.
  - On config handshake: latch the three lengths len_k = symbol_k*prb_k (10-bit unsigned, max 961, no overflow).
  - Go to the first phase with len_k!=0. If all three are 0, the config is consumed and the FSM stays in IDLE.
- PHk:
  - s_axi_config_ready=0.
  - in_axi_ready_k = (!m_axi_valid || m_axi_ready); the other two readies are 0.
  - Each stream-k handshake increments beat_cnt.
  - On the beat where beat_cnt==len_k-1: clear beat_cnt and go to the next phase j>k with len_j!=0, else IDLE.
- Output register:
  - One stage; a beat accepted at edge N is on m_axi_data/m_axi_valid after edge N (latency 1).
  - Holds stable while m_axi_valid && !m_axi_ready.
  - Full throughput: 1 beat/clk when m_axi_ready stays 1.
- Config/data interlock:
  - A new config is accepted only in IDLE, giving one bubble cycle between frames.
  - The output register may still hold the final beat of the previous frame while the next config is accepted.
- No combinational path from any in_axi_valid_k to in_axi_ready_k. in_axi_ready_k depends only on state and the output register.
- Backpressure: m_axi_ready=0 with m_axi_valid=1 drops in_axi_ready_k the same cycle. No data is lost or duplicated.
- Reset mid-frame: the frame is abandoned, the output register is cleared (any pending beat is lost), and the FSM returns to IDLE.
- Config arriving while not in IDLE: held off by s_axi_config_ready=0; the upstream source must keep it stable.

Optional Feature:
- Macro: DATA_MERGER_LAST_EN.
- Defined:
  - Adds output port m_axi_last (1 bit, reset 0).
  - m_axi_last is asserted with the final beat of each non-empty frame (the last beat of its last non-zero phase) and is registered alongside m_axi_data.
- Undefined: the port is absent and the logic is not generated.

Decomposition:
- Shared package data_router_pkg holds:
  - config_param_1 typedef;
  - field width constant FIELD_W=5;
  - LEN_W=10;
  - FSM state enum merger_state_t.
- The package is reused by data_router and its bench.
- One natural sub-module: axis_out_reg, the one-stage output register with valid/ready hold (and last when enabled).

Test Plan:
- Config (1,2,1,3,1,1), all streams ready, m_axi_ready=1 -> 6 output beats: S1:A0,A1, S2:B0,B1,B2, S3:C0. First beat appears 1 clk after the first in_axi_ready_1 handshake.
- Config (2,2,0,5,1,3) -> 4 beats from stream 1, phase 2 skipped, then 3 from stream 3. in_axi_ready_2 is never asserted.
- Config all zeros, followed by (1,1,1,1,1,1) -> first config consumed with zero output beats; second config yields 3 beats in order 1,2,3.
- Same 6-beat frame with m_axi_ready toggled in a 1-on/2-off pattern -> identical ordered sequence with no drops or duplicates. m_axi_data is stable while stalled.
- Assert reset after 3 of 6 beats -> m_axi_valid=0 and all readies 0 immediately. After release, a fresh config (1,1,1,1,1,1) produces exactly 3 correct beats.
- With DATA_MERGER_LAST_EN: config (1,2,1,3,1,1) -> m_axi_last=1 only with beat C0; config (1,1,1,1,0,0) -> m_axi_last=1 with the stream-2 beat.
